// File: rtl/hydra_pkg.sv
// Shared types and widths for the packet arbiter.
package hydra_pkg;

    localparam int unsigned PORT_W    = 4;
    localparam int unsigned PRIO_W    = 3;
    localparam int unsigned LEN_W     = 9;
    localparam int unsigned NUM_PORTS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // One pending request slot per ingress port.
    typedef struct packed {
        logic [PRIO_W-1:0] prio;
        logic [LEN_W-1:0]  len;
    } pend_entry_t;

endpackage

// File: rtl/rr_prio_select.sv
// Highest-priority pick among pending ports; ties broken round-robin from rr_ptr+1.
module rr_prio_select
    import hydra_pkg::*;
#(
    parameter int unsigned N_PORTS = hydra_pkg::NUM_PORTS
) (
    input  logic [N_PORTS-1:0]             pending,
    input  logic [N_PORTS-1:0][PRIO_W-1:0] prio,
    input  logic [PORT_W-1:0]              rr_ptr,
    output logic                           valid,
    output logic [PORT_W-1:0]              index
);

    logic [PRIO_W-1:0] max_prio;

    // Highest priority present among pending ports.
    always_comb begin
        max_prio = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (pending[i] && (prio[i] > max_prio)) begin
                max_prio = prio[i];
            end
        end
    end

    // First pending port at max priority, scanning upward from rr_ptr+1 with wrap.
    always_comb begin
        int unsigned      idx;
        logic [PORT_W-1:0] port;
        logic              found;
        idx   = 0;
        port  = '0;
        found = 1'b0;
        index = '0;
        for (int unsigned k = 1; k <= N_PORTS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            port = PORT_W'(idx);
            if (!found && pending[port] && (prio[port] == max_prio)) begin
                found = 1'b1;
                index = port;
            end
        end
        valid = |pending;
    end

endmodule

// File: rtl/packet_arbiter.sv
// Packet arbiter: per-port pending slots, priority + round-robin grant of a shared path.
// Optional idle watchdog on the granted port is enabled by defining WATCHDOG_EN.
module packet_arbiter
    import hydra_pkg::*;
#(
    parameter int unsigned NUM_PORTS   = hydra_pkg::NUM_PORTS,
    parameter int unsigned WDOG_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            new_packet,
    input  logic [NUM_PORTS-1:0][PRIO_W-1:0] prior,
    input  logic [NUM_PORTS-1:0][LEN_W-1:0]  length,
    input  logic [NUM_PORTS-1:0]            data_vld,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [PORT_W-1:0]               grant_id,
    output logic                            grant_sop,
    output logic                            grant_done,
    output logic                            timeout,
    output logic [NUM_PORTS-1:0]            drop
);

    arb_state_t state_q, state_d;

    logic [NUM_PORTS-1:0]              pending_q, pending_d;
    logic [NUM_PORTS-1:0]              drop_q, drop_d;
    logic [NUM_PORTS-1:0]              grant_q, grant_d;
    logic [NUM_PORTS-1:0][PRIO_W-1:0]  prio_q, prio_d;
    logic [NUM_PORTS-1:0][LEN_W-1:0]   len_q, len_d;
    logic [PORT_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0]                 grant_id_q, grant_id_d;
    logic [LEN_W-1:0]                  word_cnt_q, word_cnt_d;
    logic                              grant_sop_q, grant_sop_d;
    logic                              grant_done_q, grant_done_d;

    logic              sel_valid;
    logic [PORT_W-1:0] sel_idx;
    logic              word_hit_c;
    logic              last_word_c;
    logic              wdog_hit_c;

    rr_prio_select #(
        .N_PORTS (NUM_PORTS)
    ) u_select (
        .pending (pending_q),
        .prio    (prio_q),
        .rr_ptr  (rr_ptr_q),
        .valid   (sel_valid),
        .index   (sel_idx)
    );

    assign word_hit_c  = data_vld[grant_id_q];
    // Zero-length packets finish on the first grant cycle regardless of data.
    assign last_word_c = (len_q[grant_id_q] == '0) ||
                         (word_hit_c &&
                          (({1'b0, word_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q[grant_id_q]}));

`ifdef WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              timeout_q, timeout_d;

    assign wdog_hit_c = !word_hit_c && ((idle_cnt_q + WDOG_W'(1)) == WDOG_W'(WDOG_CYCLES));

    // Idle counter restarts on every owned word and on every new grant.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            idle_cnt_d = '0;
        end else if (state_q == GRANT) begin
            idle_cnt_d = word_hit_c ? '0 : (idle_cnt_q + WDOG_W'(1));
            timeout_d  = !last_word_c && wdog_hit_c;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign wdog_hit_c = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (last_word_c) begin
                    state_d = DONE;
                end else if (wdog_hit_c) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output next values; a request on the completing port wins over its clear.
    always_comb begin
        pending_d    = pending_q;
        drop_d       = drop_q;
        prio_d       = prio_q;
        len_d        = len_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        word_cnt_d   = word_cnt_q;
        grant_sop_d  = 1'b0;
        grant_done_d = 1'b0;

        if ((state_q == DONE) || ((state_q == GRANT) && (state_d == IDLE))) begin
            pending_d[grant_id_q] = 1'b0;
            rr_ptr_d              = grant_id_q;
        end

        if ((state_q == IDLE) && (state_d == GRANT)) begin
            grant_id_d  = sel_idx;
            grant_sop_d = 1'b1;
            word_cnt_d  = '0;
        end

        if (state_q == GRANT) begin
            if (word_hit_c) begin
                word_cnt_d = word_cnt_q + LEN_W'(1);
            end
            grant_done_d = (state_d == DONE);
        end

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (new_packet[i]) begin
                if (!pending_q[i] || ((state_q == DONE) && (grant_id_q == PORT_W'(i)))) begin
                    pending_d[i] = 1'b1;
                    prio_d[i]    = prior[i];
                    len_d[i]     = length[i];
                end else begin
                    drop_d[i] = 1'b1;
                end
            end
        end

        grant_d = (state_d == GRANT) ? (NUM_PORTS'(1) << grant_id_d) : '0;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            drop_q       <= '0;
            prio_q       <= '0;
            len_q        <= '0;
            rr_ptr_q     <= PORT_W'(NUM_PORTS - 1);
            grant_id_q   <= '0;
            word_cnt_q   <= '0;
            grant_q      <= '0;
            grant_sop_q  <= 1'b0;
            grant_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            prio_q       <= prio_d;
            len_q        <= len_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            word_cnt_q   <= word_cnt_d;
            grant_q      <= grant_d;
            grant_sop_q  <= grant_sop_d;
            grant_done_q <= grant_done_d;
        end
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign grant_sop  = grant_sop_q;
    assign grant_done = grant_done_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter with a request-level reference model.
module tb_packet_arbiter;

    localparam int NP = 16;
    localparam int WD = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NP-1:0]        new_packet = '0;
    logic [NP-1:0][2:0]   prior = '0;
    logic [NP-1:0][8:0]   length = '0;
    logic [NP-1:0]        data_vld = '0;
    logic [NP-1:0]        grant;
    logic [3:0]           grant_id;
    logic                 grant_sop;
    logic                 grant_done;
    logic                 timeout;
    logic [NP-1:0]        drop;

    packet_arbiter #(
        .NUM_PORTS   (NP),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .new_packet (new_packet),
        .prior      (prior),
        .length     (length),
        .data_vld   (data_vld),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_sop  (grant_sop),
        .grant_done (grant_done),
        .timeout    (timeout),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int glog[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: request slots plus "who owns the path and how far along".
    logic [NP-1:0] m_pend;
    int            m_pr [NP];
    int            m_len[NP];
    logic [NP-1:0] m_drop;
    logic [NP-1:0] m_acc;
    int            m_rr, m_mode, m_owner, m_cnt, m_idle, m_p;
    logic [NP-1:0] e_grant;
    int            e_gid;
    bit            e_sop, e_done, e_to;
    bit            m_live = 1'b0;

    function automatic int pick();
        int best = -1;
        for (int i = 0; i < NP; i++)
            if (m_pend[i] && m_pr[i] > best) best = m_pr[i];
        for (int k = 1; k <= NP; k++) begin
            int j = (m_rr + k) % NP;
            if (m_pend[j] && m_pr[j] == best) return j;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        e_sop  = 1'b0;
        e_done = 1'b0;
        e_to   = 1'b0;
        if (rst) begin
            m_live  = 1'b1;
            m_pend  = '0;
            m_drop  = '0;
            m_rr    = NP - 1;
            m_mode  = 0;
            m_owner = 0;
            m_cnt   = 0;
            m_idle  = 0;
            for (int i = 0; i < NP; i++) begin
                m_pr[i]  = 0;
                m_len[i] = 0;
            end
        end else begin
            m_acc = '0;
            for (int i = 0; i < NP; i++)
                if (new_packet[i]) begin
                    if (!m_pend[i] || (m_mode == 2 && m_owner == i)) m_acc[i] = 1'b1;
                    else m_drop[i] = 1'b1;
                end
            case (m_mode)
                0: begin
                    m_p = pick();
                    if (m_p >= 0) begin
                        m_owner = m_p; m_mode = 1; m_cnt = 0; m_idle = 0; e_sop = 1'b1;
                    end
                end
                1: begin
                    if (m_len[m_owner] == 0) begin
                        m_mode = 2; e_done = 1'b1;
                    end else if (data_vld[m_owner]) begin
                        m_cnt++; m_idle = 0;
                        if (m_cnt == m_len[m_owner]) begin
                            m_mode = 2; e_done = 1'b1;
                        end
                    end else begin
                        m_idle++;
`ifdef WATCHDOG_EN
                        if (m_idle == WD) begin
                            m_mode = 0; e_to = 1'b1; m_pend[m_owner] = 1'b0; m_rr = m_owner;
                        end
`endif
                    end
                end
                default: begin
                    m_pend[m_owner] = 1'b0; m_rr = m_owner; m_mode = 0;
                end
            endcase
            for (int i = 0; i < NP; i++)
                if (m_acc[i]) begin
                    m_pend[i] = 1'b1; m_pr[i] = int'(prior[i]); m_len[i] = int'(length[i]);
                end
        end
        e_gid   = m_owner;
        e_grant = (m_mode == 1) ? (NP'(1) << m_owner) : '0;
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("grant",      32'(grant),      32'(e_grant));
            check("grant_id",   32'(grant_id),   32'(e_gid));
            check("grant_sop",  32'(grant_sop),  32'(e_sop));
            check("grant_done", 32'(grant_done), 32'(e_done));
            check("timeout",    32'(timeout),    32'(e_to));
            check("drop",       32'(drop),       32'(m_drop));
            if (grant_sop) glog.push_back(int'(grant_id));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int p, input int pr, input int len);
        new_packet[p] = 1'b1;
        prior[p]      = 3'(pr);
        length[p]     = 9'(len);
    endtask

    task automatic send(input int p, input int pr, input int len);
        arm(p, pr, len);
        tick();
        new_packet = '0;
    endtask

    task automatic wait_sop(input int p);
        int w = 0;
        while (!grant_sop && w < 40) begin
            tick();
            w++;
        end
        check("sop_seen", 32'(grant_sop), 32'd1);
        check("sop_port", 32'(grant_id), 32'(p));
    endtask

    task automatic serve(input int p, input int n);
        wait_sop(p);
        for (int k = 0; k < n; k++) begin
            data_vld[p] = 1'b1;
            tick();
        end
        data_vld = '0;
        check("done_pulse", 32'(grant_done), 32'd1);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_drop",  32'(drop),  32'h0);

        // Single request on port 3, four words.
        send(3, 2, 4);
        check("s1_wait", 32'(grant), 32'h0);
        tick();
        check("s1_grant", 32'(grant), 32'h0008);
        check("s1_sop",   32'(grant_sop), 32'd1);
        check("s1_id",    32'(grant_id), 32'd3);
        data_vld[3] = 1'b1;
        repeat (3) tick();
        check("s1_not_done", 32'(grant_done), 32'd0);
        tick();
        data_vld = '0;
        check("s1_done",  32'(grant_done), 32'd1);
        check("s1_gone",  32'(grant), 32'h0);
        tick();
        check("s1_id_hold", 32'(grant_id), 32'd3);

        // Priority: 9 (prio 6) before 1 (prio 1).
        arm(1, 1, 2);
        arm(9, 6, 2);
        tick();
        new_packet = '0;
        serve(9, 2);
        serve(1, 2);

        // Round-robin among equal priorities.
        glog.delete();
        arm(2, 4, 1);
        arm(5, 4, 1);
        arm(14, 4, 1);
        tick();
        new_packet = '0;
        serve(2, 1);
        send(2, 4, 1);
        serve(5, 1);
        serve(14, 1);
        serve(2, 1);
        check("rr_count", 32'(glog.size()), 32'd4);
        if (glog.size() == 4) begin
            check("rr_0", 32'(glog[0]), 32'd2);
            check("rr_1", 32'(glog[1]), 32'd5);
            check("rr_2", 32'(glog[2]), 32'd14);
            check("rr_3", 32'(glog[3]), 32'd2);
        end

        // Drop: second request while port 7 is pending.
        glog.delete();
        send(7, 3, 2);
        send(7, 3, 2);
        check("drop7", 32'(drop), 32'h0080);
        serve(7, 2);
        repeat (6) tick();
        check("drop_one_grant", 32'(glog.size()), 32'd1);
        check("drop_idle", 32'(grant), 32'h0);

        // Re-request on port 0 in its DONE cycle.
        send(0, 5, 1);
        wait_sop(0);
        data_vld[0] = 1'b1;
        tick();
        data_vld = '0;
        check("s5_done", 32'(grant_done), 32'd1);
        arm(0, 5, 1);
        tick();
        new_packet = '0;
        check("s5_no_drop", 32'(drop), 32'h0080);
        serve(0, 1);

        // Watchdog on port 4 with no data.
        send(4, 2, 3);
        wait_sop(4);
`ifdef WATCHDOG_EN
        begin
            int w = 0;
            while (!timeout && w < 200) begin
                tick();
                w++;
            end
            check("wd_cycles", 32'(w), 32'd64);
            check("wd_pulse",  32'(timeout), 32'd1);
            check("wd_grant",  32'(grant), 32'h0);
        end
        tick();
        check("wd_idle", 32'(grant), 32'h0);
        send(6, 1, 5);
        wait_sop(6);
`else
        repeat (100) tick();
        check("hold_grant",   32'(grant), 32'h0010);
        check("hold_timeout", 32'(timeout), 32'd0);
`endif

        // Reset in the middle of a grant.
        rst = 1'b1;
        tick();
        check("rg_grant", 32'(grant), 32'h0);
        check("rg_done",  32'(grant_done), 32'd0);
        check("rg_to",    32'(timeout), 32'd0);
        check("rg_drop",  32'(drop), 32'h0);
        rst = 1'b0;
        tick();
        tick();
        check("rg_stay_idle", 32'(grant), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 16, is the number of requesting ingress ports.
REQ-002 Parameter WDOG_CYCLES, default 64, is the watchdog idle limit in cycles; it is used only when WATCHDOG_EN is defined.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 new_packet  in  NUM_PORTS  per-port one-cycle pulse: control frame parsed.
REQ-006 prior  in  NUM_PORTS x 3  per-port priority; 7 is highest; sampled with new_packet.
REQ-007 length  in  NUM_PORTS x 9  per-port packet length in words; sampled with new_packet.
REQ-008 data_vld  in  NUM_PORTS  per-port word-valid strobe from the ingress buffer.
REQ-009 grant  out  NUM_PORTS  one-hot; the port currently owning the shared path.
REQ-010 grant_id  out  4  binary index of the granted port.
REQ-011 grant_sop  out  1  one-cycle pulse in the first cycle of each grant.
REQ-012 grant_done  out  1  one-cycle pulse when a packet completes.
REQ-013 timeout  out  1  one-cycle pulse when a grant is aborted by the watchdog.
REQ-014 drop  out  NUM_PORTS  sticky flag: a new_packet arrived while that port was already pending.

Function
REQ-015 Each port SHALL hold one pending entry {prior, length}; new_packet[i] SHALL set pending[i] and capture prior[i] and length[i].
REQ-016 A new_packet on an already-pending, non-completing port SHALL be ignored and SHALL set drop[i].
REQ-017 FSM states SHALL be IDLE, GRANT and DONE.
REQ-018 IDLE: if any port is pending, the block SHALL choose the highest captured priority and break ties round-robin, starting at rr_ptr+1 and wrapping from NUM_PORTS-1 to 0.
REQ-019 The choice SHALL be registered: the next cycle enters GRANT with grant, grant_id and grant_sop valid and word_cnt=0.
REQ-020 GRANT: each data_vld[grant_id] SHALL increment word_cnt; data_vld on other ports SHALL be ignored.
REQ-021 When word_cnt+1 equals the captured length on a valid word, the next state SHALL be DONE; a captured length of 0 SHALL go to DONE on the first GRANT cycle.
REQ-022 DONE, one cycle: grant_done=1, grant=0, pending[grant_id] cleared, rr_ptr<=grant_id, then IDLE. The minimum gap between grants is therefore 2 cycles.
REQ-023 A new_packet on the completing port in the DONE cycle SHALL be accepted (set wins over clear) and SHALL NOT set drop.
REQ-024 word_cnt SHALL be 9 bits and never wraps, since length is at most 511.
REQ-025 grant SHALL be all-zero outside GRANT, and grant_id SHALL hold its last value.

Reset
REQ-026 On rst: state=IDLE, pending=0, drop=0, rr_ptr=NUM_PORTS-1 (so port 0 is served first), word_cnt=0, and all outputs 0.
REQ-027 rst during GRANT SHALL abandon the grant without asserting grant_done or timeout.

Configuration
REQ-028 With WATCHDOG_EN defined: in GRANT, an idle counter SHALL reset on each data_vld[grant_id] and otherwise increment.
REQ-029 With WATCHDOG_EN, reaching WDOG_CYCLES SHALL pulse timeout, clear pending[grant_id], update rr_ptr and return to IDLE, with no grant_done.
REQ-030 Without WATCHDOG_EN: GRANT waits indefinitely, timeout is tied to 0, and no idle counter exists.

Structure
REQ-031 Shared package hydra_pkg SHALL hold PORT_W=4, PRIO_W=3, LEN_W=9, NUM_PORTS=16 and an arb_state_t enum {IDLE, GRANT, DONE}.
REQ-032 The priority/round-robin selection SHALL be one combinational sub-module, rr_prio_select (inputs pending, prio vector, rr_ptr; outputs valid and index).

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Single request: port 3 new_packet, prior=2, length=4, then 4 data_vld -> grant_sop 1 cycle later, grant=0x0008, grant_done after the 4th word.
- Priority: ports 1 (prior 1) and 9 (prior 6) request in the same cycle -> port 9 granted first, then port 1.
- Round-robin: ports 2, 5 and 14 all at prior 4, repeated after each completion -> grant order 2, 5, 14, 2.
- Drop: port 7 gets a second new_packet while pending -> drop[7]=1, and only one grant is issued.
- Same-cycle re-request: port 0 new_packet in its DONE cycle -> pending re-set, drop[0]=0, port 0 granted again.
- Watchdog, with WATCHDOG_EN and WDOG_CYCLES=64: grant to port 4 with no data_vld -> timeout after 64 cycles, then IDLE; without the macro, the grant holds and timeout stays 0.
